// File: rtl/cpu_onchip_mem_copy_master.sv
// Avalon-MM copy master: moves a block of 32-bit words from a source region
// to a destination region, one word at a time (read, hold, write).
//
// Ports:
//   clk, reset_n        - clock, synchronous active-low reset
//   start               - 1-cycle request, ignored while busy
//   src_addr, dst_addr  - byte addresses, low two bits ignored
//   word_count          - number of words to copy (0 = immediate done)
//   abort               - level, honoured only at a write accept
//   busy, done, aborted - status to the control logic
//   avm_*               - Avalon-MM master port towards the on-chip RAM
module cpu_onchip_mem_copy_master #(
  parameter int ADDR_W = 17,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [31:0]       data_q, data_d;
  logic              aborted_q, aborted_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    aborted_d = aborted_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Addresses are stored word-aligned so the bus never sees bits [1:0].
          src_d     = src_addr & WORD_MASK;
          dst_d     = dst_addr & WORD_MASK;
          rem_d     = word_count;
          aborted_d = 1'b0;
          state_d   = (word_count == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!avm_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          data_d  = avm_readdata;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (!avm_waitrequest) begin
          src_d = src_q + WORD_STEP;  // wraps modulo 2^ADDR_W
          dst_d = dst_q + WORD_STEP;
          rem_d = rem_q - LEN_W'(1);
          // The last word always completes normally, even with abort high.
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else if (abort) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs decode straight from state, so a reset drops
  // any pending request in the very next cycle.
  always_comb begin
    avm_read    = (state_q == S_RD_REQ);
    avm_write   = (state_q == S_WR_REQ);
    avm_address = '0;
    if (state_q == S_RD_REQ) avm_address = src_q;
    if (state_q == S_WR_REQ) avm_address = dst_q;
  end

  assign avm_writedata  = data_q;
  assign avm_byteenable = 4'hF;
  assign busy    = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                   (state_q == S_WR_REQ);
  assign done    = (state_q == S_DONE);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_cpu_onchip_mem_copy_master.sv
module tb_cpu_onchip_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [16:0] src_addr, dst_addr;
  logic [14:0] word_count;
  logic        abort;
  logic        busy, done, aborted;
  logic [16:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  cpu_onchip_mem_copy_master #(.ADDR_W(17), .LEN_W(15)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  // ---------------- slave model: RAM with 1-cycle read latency -------------
  logic [31:0] mem [32768];
  int          ws;          // stall cycles applied to every request
  int          stall_cnt;
  logic [16:0] rd_q [$];
  logic [16:0] wa_q [$];
  logic [31:0] wd_q [$];
  int          stall_bad, both_bad, be_bad;
  logic        prev_stall, prev_rd, prev_wr;
  logic [16:0] prev_addr;
  logic [31:0] prev_wd;

  assign avm_waitrequest = reset_n && (avm_read || avm_write) && (stall_cnt < ws);

  initial begin
    stall_cnt = 0; stall_bad = 0; both_bad = 0; be_bad = 0;
    prev_stall = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
  end

  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (!reset_n) begin
      stall_cnt  <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (avm_read && avm_write) both_bad <= both_bad + 1;
      if ((avm_read || avm_write) && avm_byteenable != 4'hF) be_bad <= be_bad + 1;
      if (prev_stall && !(avm_read == prev_rd && avm_write == prev_wr &&
          avm_address == prev_addr && (!prev_wr || avm_writedata == prev_wd)))
        stall_bad <= stall_bad + 1;
      prev_stall <= avm_waitrequest;
      prev_rd    <= avm_read;
      prev_wr    <= avm_write;
      prev_addr  <= avm_address;
      prev_wd    <= avm_writedata;
      if (avm_read || avm_write) begin
        if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else begin
          stall_cnt <= 0;
          if (avm_read) begin
            avm_readdatavalid <= 1'b1;
            avm_readdata      <= mem[avm_address[16:2]];
            rd_q.push_back(avm_address);
          end else begin
            wa_q.push_back(avm_address);
            wd_q.push_back(avm_writedata);
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [16:0] src;
    logic [16:0] dst;
    logic [14:0] cnt;
    int          ws;      // wait states per request
    int          ab;      // raise abort once this many reads accepted (0 = never)
    int          rs;      // cycle at which a second start is pulsed (0 = never)
    int          exp_rd;
    int          exp_wr;
    logic        exp_ab;
    int          exp_cyc; // cycle (after start edge) at which done is high
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input string nm, input vec_t v);
    int cyc, busy_cyc, rb, wb, nr, nw, seq_bad;
    logic [16:0] ea;
    logic [14:0] wi;
    ws = v.ws;
    rb = rd_q.size();
    wb = wa_q.size();
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; word_count = v.cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; busy_cyc = 0;
    while (!done && cyc < 500) begin
      if (busy) busy_cyc++;
      if (v.ab != 0 && (rd_q.size() - rb) >= v.ab) abort = 1'b1;
      if (v.rs != 0 && cyc == v.rs) begin
        start = 1'b1; src_addr = 17'h5000; dst_addr = 17'h6000; word_count = 15'd2;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    nr = rd_q.size() - rb;
    nw = wa_q.size() - wb;
    chk({nm, ".done_cycle"}, cyc, v.exp_cyc);
    chk({nm, ".busy_at_done"}, busy, 0);
    chk({nm, ".busy_cycles"}, busy_cyc, v.exp_cyc - 1);
    chk({nm, ".aborted"}, aborted, v.exp_ab);
    chk({nm, ".reads"}, nr, v.exp_rd);
    chk({nm, ".writes"}, nw, v.exp_wr);
    seq_bad = 0;
    for (int i = 0; i < nr && i < 64; i++) begin
      ea = (v.src & ~17'h3) + 17'(4 * i);
      if (rd_q[rb + i] !== ea) seq_bad++;
    end
    for (int i = 0; i < nw && i < 64; i++) begin
      ea = (v.dst & ~17'h3) + 17'(4 * i);
      wi = v.src[16:2] + 15'(i);
      if (wa_q[wb + i] !== ea || wd_q[wb + i] !== mem[wi]) seq_bad++;
    end
    chk({nm, ".addr_data_errors"}, seq_bad, 0);
    abort = 1'b0;
    @(negedge clk);
    chk({nm, ".aborted_hold"}, aborted, v.exp_ab);
    chk({nm, ".done_one_cycle"}, done, 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ws = 0;
    src_addr = '0; dst_addr = '0; word_count = '0;
    for (int w = 0; w < 32768; w++) mem[w] = {8'h5A, 9'h0, w[14:0]};
    mem[0] = 32'h11111111; mem[1] = 32'h22222222;
    mem[2] = 32'h33333333; mem[3] = 32'h44444444;

    //          src       dst       cnt    ws ab rs rd wr ab    cyc
    vecs[0] = '{17'h00000, 17'h01000, 15'd4, 0, 0, 0, 4, 4, 1'b0, 13};
    vecs[1] = '{17'h00200, 17'h01200, 15'd2, 3, 0, 0, 2, 2, 1'b0, 19};
    vecs[2] = '{17'h00040, 17'h00080, 15'd0, 0, 0, 0, 0, 0, 1'b0, 1};
    vecs[3] = '{17'h1FFFC, 17'h02000, 15'd2, 0, 0, 0, 2, 2, 1'b0, 7};
    vecs[4] = '{17'h00003, 17'h00103, 15'd1, 0, 0, 0, 1, 1, 1'b0, 4};
    vecs[5] = '{17'h00400, 17'h00800, 15'd8, 0, 3, 0, 3, 3, 1'b1, 10};
    vecs[6] = '{17'h00500, 17'h00900, 15'd1, 0, 1, 0, 1, 1, 1'b0, 4};
    vecs[7] = '{17'h00000, 17'h03000, 15'd4, 0, 0, 5, 4, 4, 1'b0, 13};

    repeat (3) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.aborted", aborted, 0);
    chk("reset.read", avm_read, 0);
    chk("reset.write", avm_write, 0);
    chk("reset.address", avm_address, 0);
    chk("reset.writedata", avm_writedata, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while a write is stalled by waitrequest.
    ws = 15;
    @(negedge clk);
    src_addr = 17'h600; dst_addr = 17'hA00; word_count = 15'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!avm_write && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid.write_seen", avm_write, 1);
    chk("rst_mid.stalled", avm_waitrequest, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.write", avm_write, 0);
    chk("rst_mid.read", avm_read, 0);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.done", done, 0);
    reset_n = 1'b1;
    ws = 0;
    run_vec("after_reset", vecs[0]);

    chk("stall_stability_errors", stall_bad, 0);
    chk("read_write_overlap", both_bad, 0);
    chk("byteenable_errors", be_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_onchip_mem_copy_master.md
Name: cpu_onchip_mem_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from a source region to a destination region.
- Targets the on-chip memory slave (s1/s2) in the cpu system through the interconnect.
- Read-then-write, one word in flight: each word is read, held in a data register, then written.
- Driven by local start/len/address inputs; reports busy, done and aborted status to the control logic.

Parameters:
- ADDR_W, 17, byte-address width of the master port (32768 words x 4 bytes).
- LEN_W, 15, width of the word_count input in words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  1-cycle request to begin a copy; ignored while busy=1.
- src_addr  input  ADDR_W  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr  input  ADDR_W  destination byte address; bits [1:0] ignored.
- word_count  input  LEN_W  number of 32-bit words to copy.
- abort  input  1  level; stop at the next word boundary.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  1-cycle pulse when a copy completes or aborts.
- aborted  output  1  valid with done; 1 = stopped early; holds until the next start.
- avm_address  output  ADDR_W  byte address, word-aligned.
- avm_read  output  1  read request.
- avm_write  output  1  write request.
- avm_byteenable  output  4  constant 4'hF.
- avm_writedata  output  32  write data.
- avm_readdata  input  32  read data.
- avm_readdatavalid  input  1  read data valid.
- avm_waitrequest  input  1  slave stall.

Behaviour:
- Reset (reset_n=0 at a clk edge), outputs:
  - busy, done, aborted, avm_read, avm_write = 0
  - avm_address = 0, avm_writedata = 0
  - state = IDLE
  - Any in-flight transfer is dropped immediately.
- IDLE:
  - On start with word_count != 0: latch src, dst and remaining=word_count; clear aborted; go to RD_REQ (busy=1 next cycle).
  - On start with word_count == 0: go to DONE; no bus traffic; aborted=0.
- RD_REQ:
  - avm_read=1, avm_address={src[ADDR_W-1:2],2'b00}.
  - avm_waitrequest=1: hold read and address stable.
  - avm_waitrequest=0: go to RD_WAIT.
- RD_WAIT:
  - avm_read=0.
  - On avm_readdatavalid=1: capture avm_readdata into data_reg; go to WR_REQ.
  - readdatavalid is only honoured here; latency >= 1 cycle after read accept. The on-chip RAM gives exactly 1.
- WR_REQ:
  - avm_write=1, avm_address=dst, avm_writedata=data_reg.
  - Hold stable while avm_waitrequest=1.
  - On accept: src+=4, dst+=4, remaining-=1.
  - Then: if remaining was 1 -> DONE; else if abort=1 -> DONE with aborted=1; else -> RD_REQ.
- DONE: done=1 for exactly one cycle; busy=0 in that same cycle; -> IDLE.
- Abort:
  - Sampled only at write accept; a request is never withdrawn while waitrequest is high.
  - abort during the final word's write gives aborted=0.
- avm_read and avm_write are never both 1.
- Address arithmetic wraps modulo 2^ADDR_W, no error.
- Overlapping regions are copied in ascending order; no overlap correction.
- start while busy is ignored, and its inputs are not latched.
- Throughput with zero wait states: 3 cycles per word (RD_REQ, RD_WAIT, WR_REQ).
  - Copy of N words: busy for 3N cycles, then the done cycle.

Test Plan:
- Reset behaviour: assert reset_n=0 mid-copy, during WR_REQ with waitrequest=1 -> next cycle avm_write=0, busy=0, done=0; new start afterwards copies correctly.
- Basic copy: preload words 0x11111111..0x44444444 at 0x0000; start src=0x0000, dst=0x1000, count=4, no waitrequest -> 4 reads then 4 writes interleaved, dst holds the same 4 words, done pulses at cycle 13 after start, aborted=0.
- Wait states: waitrequest high 3 cycles on each read and write, count=2 -> address and data stable through stalls, exactly 2 reads and 2 writes accepted, correct data.
- Boundaries:
  - count=0 -> done on the next cycle with no avm_read/avm_write.
  - src=0x1FFFC, count=2 -> second read at 0x00000 (wrap).
  - src=0x0003 -> first read at 0x0000.
- Abort: count=8, assert abort during the 3rd word's RD_WAIT -> 3 writes performed, done with aborted=1, no 4th read; abort during the last write of count=1 -> aborted=0.
- Start while busy: pulse start with different addresses mid-copy -> ignored; original copy completes unchanged.
